// File: rtl/wb_p2c_bridge.sv
// Pipelined-to-classic Wishbone bridge: buffers pipelined requests and issues them one at a
// time as classic cycles. Optional watchdog enabled with `define WB_P2C_ERR_TIMEOUT_EN.
module wb_p2c_bridge #(
    parameter int unsigned G_AW         = 32,
    parameter int unsigned G_DW         = 32,
    parameter int unsigned G_FIFO_DEPTH = 4,
    parameter int unsigned G_TIMEOUT    = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [G_AW-1:0]     sl_adr_i,
    input  logic [G_DW-1:0]     sl_dat_i,
    input  logic [G_DW/8-1:0]   sl_sel_i,
    input  logic                sl_we_i,
    input  logic                sl_cyc_i,
    input  logic                sl_stb_i,
    output logic [G_DW-1:0]     sl_dat_o,
    output logic                sl_ack_o,
    output logic                sl_err_o,
    output logic                sl_stall_o,
    output logic [G_AW-1:0]     ma_adr_o,
    output logic [G_DW-1:0]     ma_dat_o,
    output logic [G_DW/8-1:0]   ma_sel_o,
    output logic                ma_we_o,
    output logic                ma_cyc_o,
    output logic                ma_stb_o,
    input  logic [G_DW-1:0]     ma_dat_i,
    input  logic                ma_ack_i,
    input  logic                ma_err_i,
    input  logic                ma_rty_i
);
    localparam int unsigned SW = G_DW / 8;
    localparam int unsigned PW = $clog2(G_FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned EW = G_AW + G_DW + SW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(G_FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StReq, StGap} state_e;

    state_e        state_q;
    logic [EW-1:0] fifo_mem [G_FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [EW-1:0] head;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          timeout;

    assign full       = (count_q == FULL_CNT);
    assign empty      = (count_q == '0);
    assign sl_stall_o = full;
    assign push       = sl_cyc_i & sl_stb_i & ~full;
    assign head       = fifo_mem[rd_ptr_q];
    assign pop        = (state_q == StReq) & (ma_ack_i | ma_err_i | timeout);

`ifdef WB_P2C_ERR_TIMEOUT_EN
    localparam int unsigned TW = $clog2(G_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_CNT = TW'(G_TIMEOUT);

    logic [TW-1:0] wd_q;

    assign timeout = (state_q == StReq) & ~(ma_ack_i | ma_err_i | ma_rty_i) &
                     (wd_q == TIMEOUT_CNT);

    // Held at zero outside REQ, so every entry into REQ starts a fresh count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd_q <= '0;
        end else if (state_q != StReq || !sl_cyc_i) begin
            wd_q <= '0;
        end else if (!(ma_ack_i | ma_err_i | ma_rty_i) && !timeout) begin
            wd_q <= wd_q + TW'(1);
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^G_TIMEOUT;
    assign timeout        = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {sl_adr_i, sl_dat_i, sl_sel_i, sl_we_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ma_adr_o <= '0;
            ma_dat_o <= '0;
            ma_sel_o <= '0;
            ma_we_o  <= 1'b0;
            ma_cyc_o <= 1'b0;
            ma_stb_o <= 1'b0;
            sl_ack_o <= 1'b0;
            sl_err_o <= 1'b0;
            sl_dat_o <= '0;
        end else if (!sl_cyc_i) begin
            // Abort: flush everything and drop the classic cycle, suppressing any response.
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ma_cyc_o <= 1'b0;
            ma_stb_o <= 1'b0;
            sl_ack_o <= 1'b0;
            sl_err_o <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q  <= count_q + CW'(push) - CW'(pop);
            sl_ack_o <= 1'b0;
            sl_err_o <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (!empty) begin
                        {ma_adr_o, ma_dat_o, ma_sel_o, ma_we_o} <= head;
                        ma_cyc_o <= 1'b1;
                        ma_stb_o <= 1'b1;
                        state_q  <= StReq;
                    end
                end
                StReq: begin
                    if (ma_err_i || timeout) begin
                        sl_err_o <= 1'b1;
                        ma_stb_o <= 1'b0;
                        state_q  <= StGap;
                    end else if (ma_ack_i) begin
                        sl_ack_o <= 1'b1;
                        sl_dat_o <= ma_dat_i;
                        ma_stb_o <= 1'b0;
                        state_q  <= StGap;
                    end else if (ma_rty_i) begin
                        ma_stb_o <= 1'b0;
                        state_q  <= StGap;
                    end
                end
                StGap: begin
                    // Head is already advanced (ack/err) or kept (retry) at this point.
                    if (!empty) begin
                        {ma_adr_o, ma_dat_o, ma_sel_o, ma_we_o} <= head;
                        ma_stb_o <= 1'b1;
                        state_q  <= StReq;
                    end else begin
                        ma_cyc_o <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                default: begin
                    ma_cyc_o <= 1'b0;
                    ma_stb_o <= 1'b0;
                    state_q  <= StIdle;
                end
            endcase
        end
    end

endmodule
